run_detect_fsm: RTL and testbench
=================================

RUN_DETECT_FSM -- requirements
Module: run_detect_fsm

Interface
REQ-001 Parameter RUN_LEN, default 2, SHALL set the run length detected; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of det_cnt; legal range 1..16.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 inp  input  1  SHALL be the serial data bit.
REQ-006 in_valid  input  1  SHALL qualify inp; 1 = sample inp this edge.
REQ-007 mode  input  2  SHALL filter detections: 00 = either polarity, 01 = runs of 1 only, 10 = runs of 0 only, 11 = treated as 00.
REQ-008 overlap  input  1  SHALL select detection style: 1 = overlapping, 0 = restart after each detection.
REQ-009 cnt_clr  input  1  SHALL synchronously clear det_cnt.
REQ-010 outp  output  1  SHALL be a registered one-cycle detection pulse.
REQ-011 det_bit  output  1  SHALL give the polarity of the most recent detected run; held between detections.
REQ-012 det_cnt  output  CNT_W  SHALL give the saturating count of detections.

Function
REQ-013 Internal state SHALL be last_bit (1 bit) and run_cnt (0..RUN_LEN); run_cnt = 0 means no run in progress.
REQ-014 On an edge with in_valid=1, if run_cnt=0 or inp != last_bit, the block SHALL load run_cnt=1 and last_bit=inp.
REQ-015 On an edge with in_valid=1, if inp = last_bit and run_cnt>0, run_cnt SHALL increment, saturating at RUN_LEN.
REQ-016 A raw match SHALL occur on a valid edge where the updated run_cnt equals RUN_LEN.
REQ-017 With overlap=1, every further valid equal bit after a raw match SHALL produce another raw match; run_cnt stays at RUN_LEN.
REQ-018 With overlap=0, run_cnt SHALL be forced to 0 on the edge of a raw match, so the next bit starts a new run.
REQ-019 A detection SHALL be a raw match whose polarity (inp) passes the mode filter sampled on the same edge.
REQ-020 Run tracking SHALL be independent of mode: filtered-out raw matches still apply REQ-018.
REQ-021 On a detection edge, outp SHALL be 1 for exactly the following cycle and det_bit SHALL load inp; otherwise outp SHALL be 0.
REQ-022 On an edge with in_valid=0, last_bit, run_cnt, det_bit and det_cnt SHALL hold and outp SHALL be 0.
REQ-023 On a detection edge, det_cnt SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-024 cnt_clr=1 SHALL set det_cnt to 0 and take priority over a same-edge increment.
REQ-025 cnt_clr SHALL NOT affect run tracking, outp or det_bit.
REQ-026 Latency SHALL be fixed: the sample completing a run is reflected on outp one clock after its sampling edge.

Reset
REQ-027 rst=1 SHALL immediately set run_cnt=0, last_bit=0, outp=0, det_bit=0 and det_cnt=0, independent of clk.
REQ-028 Reset asserted mid-run SHALL discard the partial run; after release, RUN_LEN fresh equal valid bits are needed for a detection.
REQ-029 While rst=1, all inputs SHALL be ignored.

Configuration
REQ-030 With macro RUN_DETECT_CNT_EN defined, det_cnt and cnt_clr SHALL behave as in REQ-023..REQ-025.
REQ-031 Without RUN_DETECT_CNT_EN, the counter SHALL be omitted, det_cnt SHALL be constant 0, and cnt_clr SHALL be ignored; all other behaviour is unchanged.

Verification (RUN_LEN=3, CNT_W=8, RUN_DETECT_CNT_EN defined unless stated)
REQ-032 Overlap: mode=00, overlap=1, inp=1,1,1,1 all valid -> outp pulses after the 3rd and 4th samples; det_bit=1; det_cnt=2.
REQ-033 Non-overlap: overlap=0, six valid 0s -> outp pulses after the 3rd and 6th samples only; det_bit=0; det_cnt=2.
REQ-034 Mode filter: mode=01, overlap=0, inp=0,0,0,1,1,1 -> a single pulse after the 6th sample; det_bit=1; det_cnt=1.
REQ-035 Valid gaps: inp=1,1, then one cycle with in_valid=0 (inp=0), then inp=1 valid -> detection after the third valid sample; outp=0 during the gap cycle.
REQ-036 Reset mid-run: two valid 1s, rst pulsed asynchronously between edges, then 1,1,1 -> all outputs 0 immediately on reset; the next pulse comes only after the third post-reset 1.
REQ-037 Saturation/clear: CNT_W=2, overlap=1, seven valid 1s -> det_cnt stops at 3; cnt_clr=1 on a detection edge -> det_cnt=0 and outp still pulses; build without the macro -> det_cnt always 0.

Source files
------------

// File: rtl/run_detect_fsm.sv
// run_detect_fsm: serial run-length detector with polarity filter and overlap control.
// Define RUN_DETECT_CNT_EN to build the saturating detection counter (det_cnt, cnt_clr).
module run_detect_fsm #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             outp,
  output logic             det_bit,
  output logic [CNT_W-1:0] det_cnt
);

  localparam int            RW      = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

  logic          last_bit_r;
  logic [RW-1:0] run_cnt_r;
  logic          outp_r;
  logic          det_bit_r;

  logic [RW-1:0] cnt_upd_s;
  logic [RW-1:0] run_cnt_nxt_s;
  logic          raw_s;
  logic          pass_s;
  logic          det_s;

  // Run-length update, raw match and restart decision for the current sample
  always_comb begin
    cnt_upd_s     = run_cnt_r;
    run_cnt_nxt_s = run_cnt_r;
    raw_s         = 1'b0;
    if ((run_cnt_r == {RW{1'b0}}) || (inp != last_bit_r)) begin
      cnt_upd_s = RW'(1);
    end else if (run_cnt_r == RUN_MAX) begin
      cnt_upd_s = RUN_MAX;
    end else begin
      cnt_upd_s = run_cnt_r + RW'(1);
    end
    if (in_valid) begin
      raw_s = (cnt_upd_s == RUN_MAX);
      // Non-overlapping mode restarts tracking even when the filter rejects the match
      if (raw_s && !overlap) begin
        run_cnt_nxt_s = {RW{1'b0}};
      end else begin
        run_cnt_nxt_s = cnt_upd_s;
      end
    end else begin
      raw_s         = 1'b0;
      run_cnt_nxt_s = run_cnt_r;
    end
  end

  // Polarity filter; mode 11 behaves like 00
  always_comb begin
    pass_s = 1'b1;
    case (mode)
      2'b01:   pass_s = inp;
      2'b10:   pass_s = ~inp;
      default: pass_s = 1'b1;
    endcase
    det_s = raw_s & pass_s;
  end

  // Run tracking state and registered detection outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_bit_r <= 1'b0;
      run_cnt_r  <= {RW{1'b0}};
      outp_r     <= 1'b0;
      det_bit_r  <= 1'b0;
    end else begin
      if (in_valid) begin
        last_bit_r <= inp;
        run_cnt_r  <= run_cnt_nxt_s;
      end else begin
        last_bit_r <= last_bit_r;
        run_cnt_r  <= run_cnt_r;
      end
      outp_r <= det_s;
      if (det_s) begin
        det_bit_r <= inp;
      end else begin
        det_bit_r <= det_bit_r;
      end
    end
  end

  assign outp    = outp_r;
  assign det_bit = det_bit_r;

`ifdef RUN_DETECT_CNT_EN
  logic [CNT_W-1:0] det_cnt_r;

  // Saturating detection counter; clear wins over a same-edge increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      det_cnt_r <= {CNT_W{1'b0}};
    end else if (det_s && (det_cnt_r != {CNT_W{1'b1}})) begin
      det_cnt_r <= det_cnt_r + CNT_W'(1);
    end else begin
      det_cnt_r <= det_cnt_r;
    end
  end

  assign det_cnt = det_cnt_r;
`else
  logic unused_cnt_clr_s;

  assign unused_cnt_clr_s = cnt_clr;
  assign det_cnt          = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_run_detect_fsm.sv
// Self-checking bench for run_detect_fsm: directed vector table, hand sequences and
// randomized traffic against a history-based reference model (RUN_LEN=3).
module tb_run_detect_fsm;

  localparam int RUN_LEN = 3;
`ifdef RUN_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inp;
  logic       in_valid;
  logic [1:0] mode;
  logic       overlap;
  logic       cnt_clr;
  logic       outp, det_bit;
  logic [7:0] det_cnt;
  logic       outp2, det_bit2;
  logic [1:0] det_cnt2;

  run_detect_fsm #(.RUN_LEN(RUN_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .mode(mode),
    .overlap(overlap), .cnt_clr(cnt_clr), .outp(outp), .det_bit(det_bit), .det_cnt(det_cnt)
  );

  run_detect_fsm #(.RUN_LEN(RUN_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .mode(mode),
    .overlap(overlap), .cnt_clr(cnt_clr), .outp(outp2), .det_bit(det_bit2), .det_cnt(det_cnt2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: valid bits since the last restart, newest at the back
  bit hist[$];
  bit m_outp;
  bit m_bit;
  int m_cnt8;
  int m_cnt2;

  typedef struct {
    bit       rst_b;
    bit       v;
    bit       i;
    bit [1:0] m;
    bit       o;
    bit       c;
    bit       e_outp;
    bit       e_bit;
    int       e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_outp = 1'b0;
    m_bit  = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  // A raw match is: the last RUN_LEN valid bits since restart all equal the new bit
  task automatic model_step(input bit v, input bit i, input bit [1:0] m, input bit o, input bit c);
    bit all_eq;
    bit pass;
    m_outp = 1'b0;
    if (v) begin
      hist.push_back(i);
      if (hist.size() > RUN_LEN) void'(hist.pop_front());
      all_eq = (hist.size() == RUN_LEN);
      foreach (hist[k]) if (hist[k] != i) all_eq = 1'b0;
      pass = (m == 2'b01) ? i : ((m == 2'b10) ? !i : 1'b1);
      if (all_eq && !o) hist.delete();
      if (all_eq && pass) begin
        m_outp = 1'b1;
        m_bit  = i;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    if (c) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".outp"},     outp,     m_outp);
    check({tag, ".det_bit"},  det_bit,  m_bit);
    check({tag, ".det_cnt"},  det_cnt,  CNT_EN ? m_cnt8 : 0);
    check({tag, ".outp2"},    outp2,    m_outp);
    check({tag, ".det_bit2"}, det_bit2, m_bit);
    check({tag, ".det_cnt2"}, det_cnt2, CNT_EN ? m_cnt2 : 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".outp"},     outp,     0);
    check({tag, ".det_bit"},  det_bit,  0);
    check({tag, ".det_cnt"},  det_cnt,  0);
    check({tag, ".det_cnt2"}, det_cnt2, 0);
  endtask

  // Called at a negedge: drive one sample, let it be taken, check on the next negedge
  task automatic cycle(input string tag, input bit v, input bit i, input bit [1:0] m,
                       input bit o, input bit c);
    in_valid = v;
    inp      = i;
    mode     = m;
    overlap  = o;
    cnt_clr  = c;
    model_step(v, i, m, o, c);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset pulse between edges (optionally held across one edge with live inputs)
  task automatic do_reset(input string tag, input bit across_edge);
    in_valid = 1'b1;
    inp      = 1'b1;
    cnt_clr  = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero({tag, ".async"});
    model_reset();
    if (across_edge) begin
      @(posedge clk);
      #1 check_zero({tag, ".held"});
      @(negedge clk);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    inp      = 1'b0;
    model_step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_all({tag, ".post"});
  endtask

  task automatic add(input bit r, input bit v, input bit i, input bit [1:0] m, input bit o,
                     input bit c, input bit eo, input bit eb, input int ec);
    vec_t t;
    t.rst_b = r; t.v = v; t.i = i; t.m = m; t.o = o; t.c = c;
    t.e_outp = eo; t.e_bit = eb; t.e_cnt = ec;
    tbl.push_back(t);
  endtask

  initial begin
    bit prev;
    rst      = 1'b1;
    inp      = 1'b0;
    in_valid = 1'b0;
    mode     = 2'b00;
    overlap  = 1'b0;
    cnt_clr  = 1'b0;
    model_reset();
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Overlapping run of four 1s
    add(1, 1, 1, 2'b00, 1, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 1, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 1, 0, 1, 1, 1);
    add(0, 1, 1, 2'b00, 1, 0, 1, 1, 2);
    // Non-overlapping: six 0s
    add(1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0, 1);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0, 1);
    add(0, 1, 0, 2'b00, 0, 0, 1, 0, 2);
    // Mode 01 rejects the run of 0s, accepts the run of 1s
    add(1, 1, 0, 2'b01, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b01, 0, 0, 1, 1, 1);
    // Invalid gap cycle does not break the run
    add(1, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 0, 0, 1, 1, 1);
    // Clear on a detection edge: outp still pulses
    add(1, 1, 1, 2'b00, 1, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 1, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 1, 0, 1, 1, 1);
    add(0, 1, 1, 2'b00, 1, 1, 1, 1, 0);
    add(0, 1, 1, 2'b00, 1, 0, 1, 1, 1);
    // Mode 11 acts as either polarity
    add(1, 1, 0, 2'b11, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 0, 0, 1, 0, 1);
    // Filtered-out raw match still restarts the run
    add(1, 1, 1, 2'b10, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b10, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b10, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 0, 0, 1, 1, 1);

    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].rst_b) do_reset($sformatf("tbl%0d.rst", n), 1'b0);
      cycle($sformatf("tbl%0d.model", n), tbl[n].v, tbl[n].i, tbl[n].m, tbl[n].o, tbl[n].c);
      check($sformatf("tbl%0d.outp", n),    outp,    tbl[n].e_outp);
      check($sformatf("tbl%0d.det_bit", n), det_bit, tbl[n].e_bit);
      check($sformatf("tbl%0d.det_cnt", n), det_cnt, CNT_EN ? tbl[n].e_cnt : 0);
    end

    // Saturation: seven overlapping 1s give five detections
    do_reset("sat.rst", 1'b0);
    for (int n = 0; n < 7; n++) cycle("sat", 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    check("sat.det_cnt2", det_cnt2, CNT_EN ? 3 : 0);
    check("sat.det_cnt",  det_cnt,  CNT_EN ? 5 : 0);

    // Reset mid-run discards the partial run
    do_reset("mid.rst0", 1'b0);
    cycle("mid.pre", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    cycle("mid.pre", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    do_reset("mid.rst", 1'b0);
    for (int n = 0; n < 3; n++) begin
      cycle("mid.post", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
      check($sformatf("mid.outp%0d", n), outp, (n == 2) ? 1 : 0);
    end

    // Reset held across an edge ignores live inputs
    do_reset("held", 1'b1);

    // Randomized traffic with occasional resets
    prev = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset("rnd.rst", 1'b0);
      end else begin
        if ($urandom_range(3) == 0) prev = ~prev;
        cycle("rnd", $urandom_range(3) != 0, prev, 2'($urandom_range(3)),
              $urandom_range(1) == 1, $urandom_range(19) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
